// File: rtl/multi_alarm_clock_if.sv
// UART byte channel into the alarm clock plus the per-command result pulses.
// rx_rdy is a valid-only strobe: each rx_rdy=1 cycle carries one byte in rx_data, there is no ready/backpressure, and the slave must consume it that cycle.
interface multi_alarm_clock_if;
  logic       rx_rdy;
  logic [7:0] rx_data;
  logic       cmd_ok;
  logic       cmd_err;

  modport master (output rx_rdy, rx_data, input cmd_ok, cmd_err);
  modport slave  (input rx_rdy, rx_data, output cmd_ok, cmd_err);
endinterface

// File: rtl/multi_alarm_clock.sv
// MM:SS BCD clock with NUM_ALARMS armable/snoozable alarms, configured by ASCII commands.
// Parser state is exported on dbg_pstate for external checkers.
module multi_alarm_clock #(
  parameter int NUM_ALARMS = 4,
  parameter int SNOOZE_SEC = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    one_sec_strb,
  multi_alarm_clock_if.slave      rx,
  output logic [3:0]              t_mtens,
  output logic [3:0]              t_mones,
  output logic [3:0]              t_stens,
  output logic [3:0]              t_sones,
  output logic                    run,
  output logic [2*NUM_ALARMS-1:0] alarm_state,
  output logic                    alarm_any_trig,
  output logic [3:0]              dbg_pstate
);

  typedef enum logic [3:0] {
    P_IDLE, P_T_M1, P_T_M0, P_T_S1, P_T_S0, P_T_CR,
    P_A_N, P_A_M1, P_A_M0, P_A_S1, P_A_S0, P_A_CR, P_ARM_N
  } pstate_t;

  typedef enum logic [1:0] {
    A_IDLE = 2'b00, A_ARMED = 2'b01, A_TRIG = 2'b10, A_SNOOZE = 2'b11
  } astate_t;

  localparam logic [7:0] CH_MAX = 8'(48 + NUM_ALARMS - 1);

  pstate_t     pstate, pstate_n;
  astate_t     ast [NUM_ALARMS];
  logic [5:0]  cnt [NUM_ALARMS];
  logic [15:0] alarm_val [NUM_ALARMS];
  logic [NUM_ALARMS-1:0] match, match_q;
  logic [15:0] sh_time;
  logic [2:0]  sh_ch;
  logic [15:0] time_val;

  logic ok_n, err_n, bad;
  logic st_m1, st_m0, st_s1, st_s0, st_ch;
  logic load_time, load_alarm, arm_toggle, snooze_cmd;
  logic is_d9, is_d5, is_cr, ch_ok;

  assign time_val = {t_mtens, t_mones, t_stens, t_sones};
  assign is_d9 = (rx.rx_data >= 8'h30) && (rx.rx_data <= 8'h39);
  assign is_d5 = (rx.rx_data >= 8'h30) && (rx.rx_data <= 8'h35);
  assign is_cr = (rx.rx_data == 8'h0D);
  assign ch_ok = (rx.rx_data >= 8'h30) && (rx.rx_data <= CH_MAX);

  always_ff @(posedge clk) begin
    if (rst) pstate <= P_IDLE;
    else     pstate <= pstate_n;
  end

  // A failing byte always lands in P_IDLE without being decoded as a new command.
  always_comb begin
    pstate_n = pstate;
    ok_n = 1'b0; err_n = 1'b0; bad = 1'b0;
    st_m1 = 1'b0; st_m0 = 1'b0; st_s1 = 1'b0; st_s0 = 1'b0; st_ch = 1'b0;
    load_time = 1'b0; load_alarm = 1'b0; arm_toggle = 1'b0; snooze_cmd = 1'b0;
    if (rx.rx_rdy) begin
      case (pstate)
        P_IDLE: begin
          case (rx.rx_data)
            8'h6C:   pstate_n = P_T_M1;
            8'h61:   pstate_n = P_A_N;
            8'h40:   pstate_n = P_ARM_N;
            8'h73:   begin snooze_cmd = 1'b1; ok_n = 1'b1; end
            8'h0D:   ;
            default: err_n = 1'b1;
          endcase
        end
        P_T_M1:  if (is_d5) begin st_m1 = 1'b1; pstate_n = P_T_M0; end else bad = 1'b1;
        P_T_M0:  if (is_d9) begin st_m0 = 1'b1; pstate_n = P_T_S1; end else bad = 1'b1;
        P_T_S1:  if (is_d5) begin st_s1 = 1'b1; pstate_n = P_T_S0; end else bad = 1'b1;
        P_T_S0:  if (is_d9) begin st_s0 = 1'b1; pstate_n = P_T_CR; end else bad = 1'b1;
        P_T_CR:  if (is_cr) begin load_time = 1'b1; ok_n = 1'b1; pstate_n = P_IDLE; end
                 else bad = 1'b1;
        P_A_N:   if (ch_ok) begin st_ch = 1'b1; pstate_n = P_A_M1; end else bad = 1'b1;
        P_A_M1:  if (is_d5) begin st_m1 = 1'b1; pstate_n = P_A_M0; end else bad = 1'b1;
        P_A_M0:  if (is_d9) begin st_m0 = 1'b1; pstate_n = P_A_S1; end else bad = 1'b1;
        P_A_S1:  if (is_d5) begin st_s1 = 1'b1; pstate_n = P_A_S0; end else bad = 1'b1;
        P_A_S0:  if (is_d9) begin st_s0 = 1'b1; pstate_n = P_A_CR; end else bad = 1'b1;
        P_A_CR:  if (is_cr) begin load_alarm = 1'b1; ok_n = 1'b1; pstate_n = P_IDLE; end
                 else bad = 1'b1;
        P_ARM_N: if (ch_ok) begin arm_toggle = 1'b1; ok_n = 1'b1; pstate_n = P_IDLE; end
                 else bad = 1'b1;
        default: bad = 1'b1;
      endcase
      if (bad) begin
        err_n    = 1'b1;
        pstate_n = P_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sh_time    <= '0;
      sh_ch      <= '0;
      rx.cmd_ok  <= 1'b0;
      rx.cmd_err <= 1'b0;
    end else begin
      rx.cmd_ok  <= ok_n;
      rx.cmd_err <= err_n;
      if (st_m1) sh_time[15:12] <= rx.rx_data[3:0];
      if (st_m0) sh_time[11:8]  <= rx.rx_data[3:0];
      if (st_s1) sh_time[7:4]   <= rx.rx_data[3:0];
      if (st_s0) sh_time[3:0]   <= rx.rx_data[3:0];
      if (st_ch) sh_ch          <= rx.rx_data[2:0];
    end
  end

  // A time load takes priority over a coincident second strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      {t_mtens, t_mones, t_stens, t_sones} <= '0;
    end else if (load_time) begin
      {t_mtens, t_mones, t_stens, t_sones} <= sh_time;
    end else if (one_sec_strb) begin
      if (t_sones != 4'd9) t_sones <= t_sones + 4'd1;
      else begin
        t_sones <= 4'd0;
        if (t_stens != 4'd5) t_stens <= t_stens + 4'd1;
        else begin
          t_stens <= 4'd0;
          if (t_mones != 4'd9) t_mones <= t_mones + 4'd1;
          else begin
            t_mones <= 4'd0;
            t_mtens <= (t_mtens == 4'd5) ? 4'd0 : t_mtens + 4'd1;
          end
        end
      end
    end
  end

  always_comb begin
    match = '0;
    for (int k = 0; k < NUM_ALARMS; k++) match[k] = (time_val == alarm_val[k]);
  end

  // Toggle-arm outranks snooze and match edges; a match edge only arms-to-trigger.
  always_ff @(posedge clk) begin
    if (rst) begin
      match_q <= '0;
      for (int k = 0; k < NUM_ALARMS; k++) begin
        ast[k]       <= A_IDLE;
        cnt[k]       <= '0;
        alarm_val[k] <= '0;
      end
    end else begin
      match_q <= match;
      for (int k = 0; k < NUM_ALARMS; k++) begin
        if (load_alarm && sh_ch == 3'(k)) alarm_val[k] <= sh_time;
        if (arm_toggle && rx.rx_data[2:0] == 3'(k)) begin
          ast[k] <= (ast[k] == A_IDLE) ? A_ARMED : A_IDLE;
          cnt[k] <= '0;
        end else if (snooze_cmd && ast[k] == A_TRIG) begin
          ast[k] <= A_SNOOZE;
          cnt[k] <= 6'(SNOOZE_SEC);
        end else if (ast[k] == A_ARMED && match[k] && !match_q[k]) begin
          ast[k] <= A_TRIG;
        end else if (ast[k] == A_SNOOZE && one_sec_strb) begin
          cnt[k] <= cnt[k] - 6'd1;
          if (cnt[k] == 6'd1) ast[k] <= A_TRIG;
        end
      end
    end
  end

  always_comb begin
    alarm_state    = '0;
    alarm_any_trig = 1'b0;
    for (int k = 0; k < NUM_ALARMS; k++) begin
      alarm_state[2*k +: 2] = ast[k];
      if (ast[k] == A_TRIG) alarm_any_trig = 1'b1;
    end
  end

  assign run        = (pstate == P_IDLE);
  assign dbg_pstate = pstate;

endmodule

// File: tb/tb_multi_alarm_clock.sv
// Randomised + directed bench for multi_alarm_clock against a seconds-based command model.
module tb_multi_alarm_clock;
  localparam int NA = 4;
  localparam int SN = 10;
  localparam int S_IDLE = 0, S_ARMED = 1, S_TRIG = 2, S_SNZ = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic strb = 1'b0;
  logic [3:0] t_mtens, t_mones, t_stens, t_sones, dbg_pstate;
  logic run, alarm_any_trig;
  logic [2*NA-1:0] alarm_state;

  multi_alarm_clock_if bus ();

  multi_alarm_clock #(.NUM_ALARMS(NA), .SNOOZE_SEC(SN)) dut (
    .clk(clk), .rst(rst), .one_sec_strb(strb), .rx(bus),
    .t_mtens(t_mtens), .t_mones(t_mones), .t_stens(t_stens), .t_sones(t_sones),
    .run(run), .alarm_state(alarm_state), .alarm_any_trig(alarm_any_trig),
    .dbg_pstate(dbg_pstate)
  );

  always #5 clk = ~clk;

  // ---------------- reference model (time in plain seconds) ----------------
  int         m_time;
  int         m_alarm [NA];
  int         m_st [NA];
  int         m_cnt [NA];
  bit         m_prev [NA];
  logic [7:0] m_cmd [$];
  bit         m_ok, m_err;
  int         checks = 0;
  int         errors = 0;

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(int t);
    int mm, ss;
    mm = t / 60;
    ss = t % 60;
    return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  function automatic bit digit_ok(int p, int v);
    return v >= 0 && v <= ((p == 1 || p == 3) ? 5 : 9);
  endfunction

  function automatic bit field_ok(logic [7:0] kind, int pos, logic [7:0] b);
    int v;
    v = int'(b) - 48;
    case (kind)
      8'h40:   return pos == 1 && v >= 0 && v < NA;
      8'h6C:   return (pos == 5) ? (b == 8'h0D) : digit_ok(pos, v);
      8'h61: begin
        if (pos == 1) return v >= 0 && v < NA;
        if (pos == 6) return b == 8'h0D;
        return digit_ok(pos - 1, v);
      end
      default: return 1'b0;
    endcase
  endfunction

  function automatic int secs_at(int i);
    return ((int'(m_cmd[i]) - 48) * 10 + int'(m_cmd[i+1]) - 48) * 60
         + (int'(m_cmd[i+2]) - 48) * 10 + int'(m_cmd[i+3]) - 48;
  endfunction

  task automatic model_reset();
    m_time = 0;
    m_ok = 0;
    m_err = 0;
    m_cmd.delete();
    for (int k = 0; k < NA; k++) begin
      m_alarm[k] = 0; m_st[k] = S_IDLE; m_cnt[k] = 0; m_prev[k] = 0;
    end
  endtask

  task automatic model_step(bit rdy, logic [7:0] d, bit s);
    bit edge_k [NA];
    int tog;
    bit snz, tload;
    int tval;
    tog = -1; snz = 0; tload = 0; tval = 0;
    for (int k = 0; k < NA; k++) begin
      edge_k[k] = (m_time == m_alarm[k]) && !m_prev[k];
      m_prev[k] = (m_time == m_alarm[k]);
    end
    m_ok = 0;
    m_err = 0;
    if (rdy) begin
      if (m_cmd.size() == 0) begin
        if (d == 8'h6C || d == 8'h61 || d == 8'h40) m_cmd.push_back(d);
        else if (d == 8'h73) begin snz = 1; m_ok = 1; end
        else if (d != 8'h0D) m_err = 1;
      end else if (!field_ok(m_cmd[0], m_cmd.size(), d)) begin
        m_err = 1;
        m_cmd.delete();
      end else begin
        m_cmd.push_back(d);
        if (m_cmd[0] == 8'h40) begin
          tog = int'(d) - 48; m_ok = 1; m_cmd.delete();
        end else if (m_cmd[0] == 8'h6C && m_cmd.size() == 6) begin
          tload = 1; tval = secs_at(1); m_ok = 1; m_cmd.delete();
        end else if (m_cmd[0] == 8'h61 && m_cmd.size() == 7) begin
          m_alarm[int'(m_cmd[1]) - 48] = secs_at(2); m_ok = 1; m_cmd.delete();
        end
      end
    end
    if (tload) m_time = tval;
    else if (s) m_time = (m_time + 1) % 3600;
    for (int k = 0; k < NA; k++) begin
      if (tog == k) begin
        m_st[k] = (m_st[k] == S_IDLE) ? S_ARMED : S_IDLE;
        m_cnt[k] = 0;
      end else if (snz && m_st[k] == S_TRIG) begin
        m_st[k] = S_SNZ; m_cnt[k] = SN;
      end else if (m_st[k] == S_ARMED && edge_k[k]) begin
        m_st[k] = S_TRIG;
      end else if (m_st[k] == S_SNZ && s) begin
        m_cnt[k]--;
        if (m_cnt[k] == 0) m_st[k] = S_TRIG;
      end
    end
  endtask

  task automatic compare_all();
    logic [2*NA-1:0] exp_st;
    bit any;
    exp_st = '0;
    any = 0;
    for (int k = 0; k < NA; k++) begin
      exp_st[2*k +: 2] = 2'(m_st[k]);
      if (m_st[k] == S_TRIG) any = 1;
    end
    check("time", {t_mtens, t_mones, t_stens, t_sones}, to_bcd(m_time));
    check("alarm_state", alarm_state, exp_st);
    check("any_trig", alarm_any_trig, any);
    check("cmd_ok", bus.cmd_ok, m_ok);
    check("cmd_err", bus.cmd_err, m_err);
    check("run", run, m_cmd.size() == 0);
  endtask

  // ---------------- drivers ----------------
  task automatic cycle(bit rdy, logic [7:0] d, bit s);
    @(negedge clk);
    rst = 1'b0;
    bus.rx_rdy = rdy;
    bus.rx_data = d;
    strb = s;
    @(posedge clk);
    model_step(rdy, d, s);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    bus.rx_rdy = 1'b0;
    bus.rx_data = 8'h00;
    strb = 1'b0;
    @(posedge clk);
    model_reset();
    #1;
    compare_all();
  endtask

  task automatic send_str(string s, bit rnd);
    for (int i = 0; i < s.len(); i++) begin
      cycle(1'b1, s[i], rnd ? ($urandom_range(0, 3) == 0) : 1'b0);
      if (rnd) repeat ($urandom_range(0, 2)) cycle(1'b0, 8'h00, $urandom_range(0, 3) == 0);
    end
    cycle(1'b0, 8'h00, 1'b0);
  endtask

  task automatic strobes(int n);
    repeat (n) begin
      cycle(1'b0, 8'h00, 1'b1);
      cycle(1'b0, 8'h00, 1'b0);
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [7:0] junk [8];
    junk = '{8'h6C, 8'h61, 8'h40, 8'h73, 8'h0D, 8'h30, 8'h39, 8'h78};
    bus.rx_rdy = 1'b0;
    bus.rx_data = 8'h00;
    model_reset();
    do_reset();
    check("reset_run", run, 1'b1);

    strobes(61);
    check("time_0101", {t_mtens, t_mones, t_stens, t_sones}, 16'h0101);

    send_str("l5958\015", 0);
    strobes(3);
    check("wrap_0001", {t_mtens, t_mones, t_stens, t_sones}, 16'h0001);

    send_str("a20005\015", 0);
    send_str("@2", 0);
    send_str("l0003\015", 0);
    strobes(2);
    cycle(1'b0, 8'h00, 1'b0);
    check("ch2_trig", alarm_state, 8'b0010_0000);
    check("any_trig_set", alarm_any_trig, 1'b1);

    send_str("s", 0);
    check("ch2_snooze", alarm_state, 8'b0011_0000);
    strobes(SN);
    check("ch2_retrig", alarm_state, 8'b0010_0000);
    send_str("@2", 0);
    check("ch2_idle", alarm_state, 8'b0000_0000);

    send_str("l6", 0);
    send_str("a9", 0);
    check("bad_cmd_time", {t_mtens, t_mones, t_stens, t_sones}, 16'h0015);
    check("bad_cmd_run", run, 1'b1);

    // Load coincident with a strobe, then '@' colliding with a match edge.
    send_str("l0008", 0);
    cycle(1'b1, 8'h0D, 1'b1);
    check("load_wins", {t_mtens, t_mones, t_stens, t_sones}, 16'h0008);
    send_str("a00010\015", 0);
    send_str("@0", 0);
    send_str("l0009\015", 0);
    cycle(1'b1, 8'h40, 1'b1);
    cycle(1'b1, 8'h30, 1'b0);
    cycle(1'b0, 8'h00, 1'b0);
    check("arm_beats_match", alarm_state[1:0], 2'b00);

    send_str("a1", 0);
    do_reset();
    send_str("0000\015", 0);
    check("post_reset_time", {t_mtens, t_mones, t_stens, t_sones}, 16'h0000);

    for (int it = 0; it < 400; it++) begin
      int r, ch, t;
      r = $urandom_range(0, 9);
      ch = $urandom_range(0, NA - 1);
      case (r)
        0, 1: begin
          t = (m_time + $urandom_range(1, 4)) % 3600;
          send_str($sformatf("a%0d%02d%02d\015", ch, t / 60, t % 60), 1);
        end
        2: send_str($sformatf("@%0d", ch), 1);
        3: send_str("s", 1);
        4: begin
          t = $urandom_range(0, 3599);
          send_str($sformatf("l%02d%02d\015", t / 60, t % 60), 1);
        end
        5: cycle(1'b1, junk[$urandom_range(0, 7)], $urandom_range(0, 1) == 1);
        default: strobes($urandom_range(1, 3));
      endcase
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
